// File: rtl/avalon_bus_arbiter_if.sv
// Avalon-MM port bundle shared by the arbiter's master-facing and
// slave-facing sides. "master" is the side that issues transfers,
// "slave" is the side that answers them.
interface avalon_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   readdata;
  logic                waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// Two-master / one-slave Avalon-MM arbiter. One master owns the slave port
// at a time; the owner keeps it until its transfer completes (request high
// with slave waitrequest low), the other master is stalled with waitrequest.
// Every transfer passes through IDLE, so a transfer costs at least 2 cycles.
// Optional build macro ARB_ROUND_ROBIN_EN: contested arbitration alternates
// between masters; without it master 0 always wins.
module avalon_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  avalon_bus_arbiter_if.slave  m0,
  avalon_bus_arbiter_if.slave  m1,
  avalon_bus_arbiter_if.master s,
  output logic [1:0]           grant,
  output logic                 busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

`ifdef ARB_ROUND_ROBIN_EN
  // Index of the master that completed most recently (1 after reset so
  // master 0 wins the first contested arbitration).
  logic last_grant_reg;
  logic last_grant_next;
`endif

  logic req0;
  logic req1;

  // Slave-side values selected from the owning master.
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic [BE_W-1:0]   be_mux;
  logic              rd_mux;
  logic              wr_mux;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // Read data is broadcast; each master qualifies it with its own waitrequest.
  assign m0.readdata = s.readdata;
  assign m1.readdata = s.readdata;

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_reg <= 1'b1;
`endif
    end else begin
      state_reg <= state_next;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_reg <= last_grant_next;
`endif
    end
  end

  // Next-state: arbitrate in IDLE, release on completion or dropped request.
  always_comb begin
    state_next = state_reg;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_next = last_grant_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_next = last_grant_reg ? GRANT0 : GRANT1;
`else
          state_next = GRANT0;
`endif
        end else if (req0) begin
          state_next = GRANT0;
        end else if (req1) begin
          state_next = GRANT1;
        end
      end
      GRANT0: begin
        if (!req0) begin
          // Request withdrawn mid-transfer: release without recording it.
          state_next = IDLE;
        end else if (!s.waitrequest) begin
          state_next = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_next = 1'b0;
`endif
        end
      end
      GRANT1: begin
        if (!req1) begin
          state_next = IDLE;
        end else if (!s.waitrequest) begin
          state_next = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_next = 1'b1;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: route the owner to the slave, stall everyone else.
  always_comb begin
    addr_mux       = '0;
    wdata_mux      = '0;
    be_mux         = '0;
    rd_mux         = 1'b0;
    wr_mux         = 1'b0;
    m0.waitrequest = 1'b1;
    m1.waitrequest = 1'b1;
    grant          = 2'b00;
    busy           = 1'b0;
    case (state_reg)
      GRANT0: begin
        addr_mux       = m0.address;
        wdata_mux      = m0.writedata;
        be_mux         = m0.byteenable;
        wr_mux         = m0.write;
        rd_mux         = m0.read & ~m0.write;
        m0.waitrequest = s.waitrequest;
        grant          = 2'b01;
        busy           = 1'b1;
      end
      GRANT1: begin
        addr_mux       = m1.address;
        wdata_mux      = m1.writedata;
        be_mux         = m1.byteenable;
        wr_mux         = m1.write;
        rd_mux         = m1.read & ~m1.write;
        m1.waitrequest = s.waitrequest;
        grant          = 2'b10;
        busy           = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign s.address    = addr_mux;
  assign s.writedata  = wdata_mux;
  assign s.byteenable = be_mux;
  assign s.read       = rd_mux;
  assign s.write      = wr_mux;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Self-checking bench for avalon_bus_arbiter: a transfer-level ownership
// model checked every cycle, plus directed scenarios with literal results.
module tb_avalon_bus_arbiter;

  logic clk;
  logic reset;
  logic [1:0] grant;
  logic busy;

  avalon_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  avalon_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  avalon_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

  avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if.slave),
    .m1    (m1_if.slave),
    .s     (s_if.master),
    .grant (grant),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Master drivers
  logic [31:0] drv_addr [2];
  logic [31:0] drv_wd   [2];
  logic [3:0]  drv_be   [2];
  logic        drv_rd   [2];
  logic        drv_wr   [2];
  logic        m_wait   [2];
  logic [31:0] m_rdata  [2];

  assign m0_if.address    = drv_addr[0];
  assign m0_if.writedata  = drv_wd[0];
  assign m0_if.byteenable = drv_be[0];
  assign m0_if.read       = drv_rd[0];
  assign m0_if.write      = drv_wr[0];
  assign m1_if.address    = drv_addr[1];
  assign m1_if.writedata  = drv_wd[1];
  assign m1_if.byteenable = drv_be[1];
  assign m1_if.read       = drv_rd[1];
  assign m1_if.write      = drv_wr[1];
  assign m_wait[0]  = m0_if.waitrequest;
  assign m_wait[1]  = m1_if.waitrequest;
  assign m_rdata[0] = m0_if.readdata;
  assign m_rdata[1] = m1_if.readdata;

  // Slave: ws_cfg wait cycles per access, fixed read data.
  int ws_cfg = 0;
  int ws_cnt = 0;
  logic [31:0] rdata_cfg = 32'h0;
  assign s_if.readdata = rdata_cfg;
  always_comb s_if.waitrequest = (s_if.read || s_if.write) && (ws_cnt < ws_cfg);
  always @(posedge clk) begin
    if ((s_if.read || s_if.write) && s_if.waitrequest) ws_cnt <= ws_cnt + 1;
    else ws_cnt <= 0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the slave port (-1 none), and who completed last.
  int owner = -1;
  int last_done = 1;
  bit model_valid = 0;
  always @(posedge clk) begin
    bit r0, r1;
    r0 = drv_rd[0] | drv_wr[0];
    r1 = drv_rd[1] | drv_wr[1];
    if (reset) begin
      owner = -1;
      last_done = 1;
      model_valid = 1;
    end else if (owner < 0) begin
      if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
        owner = 1 - last_done;
`else
        owner = 0;
`endif
      end else if (r0) owner = 0;
      else if (r1) owner = 1;
    end else begin
      bit r_own;
      r_own = (owner == 0) ? r0 : r1;
      if (!r_own) owner = -1;
      else if (!s_if.waitrequest) begin
        last_done = owner;
        owner = -1;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      logic [1:0] eg;
      logic eb, er, ew, ewt0, ewt1;
      logic [31:0] ea, ed;
      logic [3:0] ebe;
      if (owner < 0) begin
        eg = 2'b00; eb = 0; er = 0; ew = 0; ea = 0; ed = 0; ebe = 0;
        ewt0 = 1; ewt1 = 1;
      end else begin
        eg   = (owner == 0) ? 2'b01 : 2'b10;
        eb   = 1;
        ea   = drv_addr[owner];
        ed   = drv_wd[owner];
        ebe  = drv_be[owner];
        ew   = drv_wr[owner];
        er   = drv_rd[owner] & ~drv_wr[owner];
        ewt0 = (owner == 0) ? s_if.waitrequest : 1'b1;
        ewt1 = (owner == 1) ? s_if.waitrequest : 1'b1;
      end
      check("grant", 64'(grant), 64'(eg));
      check("busy", 64'(busy), 64'(eb));
      check("s_read", 64'(s_if.read), 64'(er));
      check("s_write", 64'(s_if.write), 64'(ew));
      check("s_address", 64'(s_if.address), 64'(ea));
      check("s_writedata", 64'(s_if.writedata), 64'(ed));
      check("s_byteenable", 64'(s_if.byteenable), 64'(ebe));
      check("m0_waitrequest", 64'(m0_if.waitrequest), 64'(ewt0));
      check("m1_waitrequest", 64'(m1_if.waitrequest), 64'(ewt1));
      check("m0_readdata", 64'(m0_if.readdata), 64'(rdata_cfg));
      check("m1_readdata", 64'(m1_if.readdata), 64'(rdata_cfg));
    end
  end

  // Grant history (one entry per new grant) and slave write observation.
  logic [1:0] grant_q[$];
  bit rec_en = 0;
  logic busy_prev = 0;
  int sw_cnt = 0;
  logic [31:0] sw_addr = 0;
  logic [31:0] sw_data = 0;
  logic [3:0]  sw_be = 0;
  always @(negedge clk) begin
    if (rec_en && busy === 1'b1 && busy_prev !== 1'b1) grant_q.push_back(grant);
    busy_prev <= busy;
    if (s_if.write === 1'b1) begin
      sw_cnt  <= sw_cnt + 1;
      sw_addr <= s_if.address;
      sw_data <= s_if.writedata;
      sw_be   <= s_if.byteenable;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // One master transfer; lat counts cycles from request to waitrequest low.
  task automatic master_xfer(input int m, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be,
                             output logic [31:0] rd, output int lat);
    bit ok;
    ok = 0;
    lat = 0;
    rd = '0;
    drv_addr[m] = a; drv_wd[m] = d; drv_be[m] = be;
    drv_wr[m] = wr; drv_rd[m] = !wr;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (m_wait[m] === 1'b0) begin
        ok = 1;
        rd = m_rdata[m];
        break;
      end
    end
    @(posedge clk);
    #1;
    drv_rd[m] = 0;
    drv_wr[m] = 0;
    check("xfer_done", 64'(ok), 64'd1);
    $display("xfer m%0d %s addr=0x%08h data=0x%08h rd=0x%08h lat=%0d",
             m, wr ? "WR" : "RD", a, d, rd, lat);
  endtask

  // Wait at most n cycles for a given grant value at a negedge.
  task automatic wait_grant(input logic [1:0] g, input int n, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < n && !seen; i++) begin
      @(negedge clk);
      if (grant === g) seen = 1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  initial begin
    logic [31:0] rd0, rd1;
    int lat0, lat1;
    logic [1:0] exp_g [8];
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
`endif
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drv_addr[i] = 0; drv_wd[i] = 0; drv_be[i] = 0; drv_rd[i] = 0; drv_wr[i] = 0;
    end

    // Reset held 3 cycles with both masters requesting.
    drv_rd[0] = 1; drv_addr[0] = 32'h4;
    drv_rd[1] = 1; drv_addr[1] = 32'h8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_s_read", 64'(s_if.read), 64'd0);
    check("rst_s_write", 64'(s_if.write), 64'd0);
    check("rst_m0_wait", 64'(m0_if.waitrequest), 64'd1);
    check("rst_m1_wait", 64'(m1_if.waitrequest), 64'd1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_still_idle", 64'(grant), 64'd0);
    tick();
    @(negedge clk);
    check("first_grant", 64'(grant), 64'b01);
    tick();
    drv_rd[0] = 0; drv_rd[1] = 0;
    tick();

    // Single read with two wait states.
    ws_cfg = 2;
    rdata_cfg = 32'hDEADBEEF;
    master_xfer(0, 0, 32'h10, 32'h0, 4'hF, rd0, lat0);
    check("read_data", 64'(rd0), 64'hDEADBEEF);
    check("read_latency", 64'(lat0), 64'd4);
    @(negedge clk);
    check("read_back_idle", 64'(grant), 64'd0);
    tick();

    // Partial write from m1 while m0 queues behind it.
    ws_cfg = 1;
    rdata_cfg = 32'h12345678;
    sw_cnt = 0;
    fork
      master_xfer(1, 1, 32'h24, 32'h0000AB00, 4'b0010, rd1, lat1);
      begin
        tick();
        tick();
        master_xfer(0, 0, 32'h40, 32'h0, 4'hF, rd0, lat0);
      end
    join
    check("pw_write_cycles", 64'(sw_cnt), 64'd2);
    check("pw_addr", 64'(sw_addr), 64'h24);
    check("pw_data", 64'(sw_data), 64'h0000AB00);
    check("pw_be", 64'(sw_be), 64'b0010);
    check("pw_m1_latency", 64'(lat1), 64'd3);
    check("pw_m0_latency", 64'(lat0), 64'd4);
    check("pw_m0_rdata", 64'(rd0), 64'h12345678);

    // Continuous contention from both masters.
    do_reset(1);
    ws_cfg = 0;
    grant_q.delete();
    rec_en = 1;
    fork
      begin
        logic [31:0] r;
        int l;
        for (int i = 0; i < 4; i++) master_xfer(0, 0, 32'h100 + 32'(i * 4), 32'h0, 4'hF, r, l);
      end
      begin
        logic [31:0] r;
        int l;
        for (int j = 0; j < 4; j++) master_xfer(1, 1, 32'h200 + 32'(j * 4), 32'hA0 + 32'(j), 4'hF, r, l);
      end
    join
    rec_en = 0;
    check("cont_count", 64'(grant_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < grant_q.size(); k++)
      check($sformatf("cont_grant%0d", k), 64'(grant_q[k]), 64'(exp_g[k]));
    tick();

    // Reset during a stalled m1 write aborts it.
    do_reset(1);
    ws_cfg = 100;
    drv_addr[1] = 32'h80; drv_wd[1] = 32'h55AA55AA; drv_be[1] = 4'hF; drv_wr[1] = 1;
    wait_grant(2'b10, 20, "abort_granted");
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("abort_pre_s_write", 64'(s_if.write), 64'd1);
    tick();
    @(negedge clk);
    check("abort_s_write", 64'(s_if.write), 64'd0);
    check("abort_grant", 64'(grant), 64'd0);
    tick();
    drv_wr[1] = 0;
    reset = 1'b0;
    tick();

    // m0 drops its read mid-wait; pending m1 write is granted next.
    do_reset(1);
    ws_cfg = 100;
    drv_addr[0] = 32'h10; drv_be[0] = 4'hF; drv_rd[0] = 1;
    drv_addr[1] = 32'h30; drv_wd[1] = 32'hCAFEF00D; drv_be[1] = 4'hF; drv_wr[1] = 1;
    wait_grant(2'b01, 20, "drop_granted");
    tick();
    tick();
    drv_rd[0] = 0;
    @(negedge clk);
    check("drop_still_g0", 64'(grant), 64'b01);
    tick();
    @(negedge clk);
    check("drop_idle", 64'(grant), 64'd0);
    tick();
    @(negedge clk);
    check("drop_then_g1", 64'(grant), 64'b10);
    check("drop_m1_wait", 64'(m1_if.waitrequest), 64'd1);
    ws_cfg = 0;
    tick();
    drv_wr[1] = 0;
    @(negedge clk);
    check("drop_final_idle", 64'(grant), 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/avalon_bus_arbiter.md
Name: avalon_bus_arbiter

Overview:
Two-master, one-slave Avalon-MM arbiter that shares the single memory port between the bus CPU (master 0) and a secondary master (master 1), e.g. a testbench loader or DMA engine. It sits between the bus CPU's Avalon master port and the memory slave. It grants one master at a time, holds the grant until that master's transfer completes, and stalls the other master with waitrequest. Transfers are non-pipelined: read data is valid in the cycle where read is high and waitrequest is low.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; byteenable width is DATA_W/8

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m0_address  in  ADDR_W  master 0 address
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_W  master 0 write data
m0_byteenable  in  DATA_W/8  master 0 byte enables
m0_readdata  out  DATA_W  master 0 read data
m0_waitrequest  out  1  master 0 stall
m1_* (address, read, write, writedata, byteenable, readdata, waitrequest)  same as m0_*  master 1 port
s_address  out  ADDR_W  slave address
s_read  out  1  slave read
s_write  out  1  slave write
s_writedata  out  DATA_W  slave write data
s_byteenable  out  DATA_W/8  slave byte enables
s_readdata  in  DATA_W  slave read data
s_waitrequest  in  1  slave stall
grant  out  2  one-hot current grant; 00 when idle
busy  out  1  high in any GRANT state

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk.
- States: IDLE, GRANT0, GRANT1, held in a registered state register. A request from master n is (mn_read | mn_write).
- Reset: state=IDLE and last_grant=1 at the next clk edge. Resulting outputs: s_read=0, s_write=0, s_address=0, s_writedata=0, s_byteenable=0, grant=00, busy=0, m0_waitrequest=1, m1_waitrequest=1.
- Reset asserted mid-transfer aborts the transfer. The slave sees s_read and s_write low from the first cycle after the reset edge.
- IDLE: all s_* outputs are 0 and both mn_waitrequest are 1.
  - Neither master requesting: stay in IDLE.
  - Only m0 requesting: go to GRANT0. Only m1 requesting: go to GRANT1.
  - Both requesting: master 0 wins (fixed priority; see Optional Feature).
- GRANTn, combinational outputs:
  - s_address, s_writedata and s_byteenable come from master n.
  - s_write = mn_write.
  - s_read = mn_read & ~mn_write. If read and write are both high, the transfer is treated as a write.
  - mn_waitrequest = s_waitrequest; the other master's waitrequest = 1.
  - grant = one-hot n; busy = 1.
- GRANTn, transitions:
  - Completion is (mn_read | mn_write) & ~s_waitrequest. On completion: last_grant <= n and state <= IDLE.
  - If master n drops its request without completing (protocol violation), state <= IDLE with no completion recorded.
  - Otherwise hold GRANTn; the grant is never preempted while s_waitrequest is high.
- Readdata: m0_readdata = m1_readdata = s_readdata at all times. A master treats it as valid only when its own waitrequest is low during a read.
- Latency: a request seen in IDLE reaches the slave one cycle later. With zero slave wait states, a transfer takes 2 cycles (1 arbitration + 1 access).
- Back-to-back transfers always pass through IDLE. Minimum 2 cycles per transfer, so a master cannot starve the other beyond one transfer when round-robin is enabled.
- A held request from the ungranted master is preserved, because waitrequest=1 forces that master to hold its signals.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: when both masters request in IDLE, grant goes to the master not equal to last_grant. Since last_grant resets to 1, m0 wins the first contested arbitration.
- Undefined: fixed priority, m0 always wins contested arbitration, and last_grant is unused. Master 1 can be starved indefinitely.

Test Plan:
- Reset check: hold reset for 3 cycles with both masters requesting → grant=00, s_read=s_write=0, both waitrequests=1. First grant appears 1 cycle after reset deasserts.
- Single read: m0 reads 0x00000010, slave returns 0xDEADBEEF with 2 wait cycles → m0_waitrequest low in cycle 4 after the request, m0_readdata=0xDEADBEEF, then state returns to IDLE.
- Contention, fixed priority: both masters request continuously → m0 is granted every transfer, m1_waitrequest stays 1.
- Contention with ARB_ROUND_ROBIN_EN: both masters request continuously → grants alternate 01,10,01,10.
- Partial write: m1 writes 0x0000AB00 with byteenable 0010 to 0x24 → slave sees s_write=1, s_byteenable=0010, s_address=0x24 for exactly the cycles until s_waitrequest is low. m0 stays stalled throughout.
- Abort paths:
  - Reset asserted during GRANT1 while s_waitrequest=1 → s_write=0 in the next cycle and state is IDLE.
  - In a separate run, m0 drops its read mid-wait → the arbiter returns to IDLE and grants a pending m1 request next.
